// File: rtl/vm_pkg.sv
// vm_pkg: shared types and parameter defaults for the vote session controller
package vm_pkg;
  typedef enum logic [2:0] {IDLE, PRESS, COMMIT, LOCKOUT, WAIT_REL, RESULT} state_t;
  typedef logic [1:0] cand_t;
  localparam int HOLD_CYCLES_DEF = 10;
  localparam int LOCKOUT_CYCLES_DEF = 16;
endpackage

// File: rtl/vm_btn_decode.sv
// vm_btn_decode: classifies the four candidate buttons (lone, multiple, lowest index)
module vm_btn_decode
  import vm_pkg::*;
(
  input  logic [3:0] btn,
  output logic       one,
  output logic       multi,
  output cand_t      idx
);
  logic [2:0] cnt;
  // population count and priority encode of the pressed buttons
  always_comb begin
    cnt = 3'(btn[0]) + 3'(btn[1]) + 3'(btn[2]) + 3'(btn[3]);
    one = cnt == 3'd1;
    multi = cnt > 3'd1;
    idx = btn[0] ? 2'd0 : btn[1] ? 2'd1 : btn[2] ? 2'd2 : 2'd3;
  end
endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: debounced single-vote session FSM with lockout and result display
module vote_session_ctrl
  import vm_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  input  logic [7:0] tally1,
  input  logic [7:0] tally2,
  input  logic [7:0] tally3,
  input  logic [7:0] tally4,
  output logic       vote_valid,
  output cand_t      vote_cand,
  output logic       reject,
  output logic       busy,
  output logic [7:0] led
);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);
  logic [3:0] btn;
  logic       one, multi, rej_nxt;
  cand_t      idx, cand, sel;
  state_t     state, nxt;
  logic [7:0] hold_cnt, lock_cnt, tally_sel;
  assign btn = {button4, button3, button2, button1};
  vm_btn_decode u_dec (
    .btn  (btn),
    .one  (one),
    .multi(multi),
    .idx  (idx)
  );
  // next-state selection; mode has priority, multi-press rejects, lone press is timed
  always_comb begin
    nxt = state;
    rej_nxt = 1'b0;
    case (state)
      IDLE: begin
        nxt = mode ? RESULT : multi ? WAIT_REL : one ? PRESS : IDLE;
        rej_nxt = !mode && multi;
      end
      PRESS: begin
        nxt = mode ? RESULT : multi ? WAIT_REL : !(one && idx == cand) ? IDLE :
              hold_cnt >= HOLD_LAST ? COMMIT : PRESS;
        rej_nxt = !mode && multi;
      end
      COMMIT:   nxt = LOCKOUT;
      LOCKOUT:  nxt = lock_cnt >= LOCK_LAST ? (mode ? RESULT : WAIT_REL) : LOCKOUT;
      WAIT_REL: nxt = mode ? RESULT : btn == 4'd0 ? IDLE : WAIT_REL;
      RESULT:   nxt = mode ? RESULT : WAIT_REL;
      default:  nxt = IDLE;
    endcase
  end
  // state, saturating counters, latched candidate and result selection
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      hold_cnt <= 8'd0;
      lock_cnt <= 8'd0;
      cand <= 2'd0;
      sel <= 2'd0;
      reject <= 1'b0;
    end else begin
      state <= nxt;
      reject <= rej_nxt;
      hold_cnt <= state == IDLE ? 8'd1 : (state == PRESS && hold_cnt != 8'hFF) ? hold_cnt + 8'd1 : hold_cnt;
      lock_cnt <= state != LOCKOUT ? 8'd0 : lock_cnt != 8'hFF ? lock_cnt + 8'd1 : lock_cnt;
      cand <= (state == IDLE && !mode && one) ? idx : cand;
      sel <= (state == RESULT && btn != 4'd0) ? idx : sel;
    end
  end
  // state-decoded outputs and the result-mode tally mux
  always_comb begin
    tally_sel = sel == 2'd0 ? tally1 : sel == 2'd1 ? tally2 : sel == 2'd2 ? tally3 : tally4;
    vote_valid = state == COMMIT;
    vote_cand = vote_valid ? cand : 2'd0;
    busy = state == PRESS || state == COMMIT || state == LOCKOUT;
    led = state == PRESS ? {4'd0, 4'b0001 << cand} :
          (state == COMMIT || state == LOCKOUT) ? 8'hFF :
          state == RESULT ? tally_sel : 8'h00;
  end
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: table vectors, directed corner sequences and a random run against a session model
module tb_vote_session_ctrl;
  localparam int H = 10;
  localparam int L = 16;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0;
  logic       button1 = 1'b0, button2 = 1'b0, button3 = 1'b0, button4 = 1'b0;
  logic [7:0] tl [4];
  logic [7:0] tally1, tally2, tally3, tally4;
  logic       vote_valid, reject, busy;
  logic [1:0] vote_cand;
  logic [7:0] led;
  int total = 0;
  int bad = 0;
  int ph, run, left, who, pick;
  bit rej;
  assign tally1 = tl[0];
  assign tally2 = tl[1];
  assign tally3 = tl[2];
  assign tally4 = tl[3];
  always #5 clock = ~clock;
  vote_session_ctrl #(.HOLD_CYCLES(H), .LOCKOUT_CYCLES(L)) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .button1   (button1),
    .button2   (button2),
    .button3   (button3),
    .button4   (button4),
    .tally1    (tally1),
    .tally2    (tally2),
    .tally3    (tally3),
    .tally4    (tally4),
    .vote_valid(vote_valid),
    .vote_cand (vote_cand),
    .reject    (reject),
    .busy      (busy),
    .led       (led)
  );
  typedef struct {
    logic       rn;
    logic       m;
    logic [3:0] b;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl [16];
  function automatic logic [12:0] o(bit v, bit [1:0] c, bit r, bit bz, bit [7:0] l);
    return {v, c, r, bz, l};
  endfunction
  function automatic int lowest(logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return 0;
  endfunction
  // session model: phases 0 idle, 1 pressing, 2 commit, 3 lockout, 4 wait-release, 5 result
  task automatic model_step(logic rn, logic m, logic [3:0] b);
    int n;
    n = $countones(b);
    if (!rn) begin
      ph = 0; run = 0; left = 0; who = 0; pick = 0; rej = 0;
      return;
    end
    rej = 0;
    if (ph == 0) begin
      if (m) ph = 5;
      else if (n > 1) begin rej = 1; ph = 4; end
      else if (n == 1) begin who = lowest(b); run = 1; ph = 1; end
    end else if (ph == 1) begin
      if (m) ph = 5;
      else if (n > 1) begin rej = 1; ph = 4; end
      else if (n == 1 && lowest(b) == who) begin run++; if (run == H) ph = 2; end
      else ph = 0;
    end else if (ph == 2) begin
      ph = 3; left = L;
    end else if (ph == 3) begin
      left--;
      if (left == 0) ph = m ? 5 : 4;
    end else if (ph == 4) begin
      if (m) ph = 5;
      else if (n == 0) ph = 0;
    end else begin
      if (n > 0) pick = lowest(b);
      if (!m) ph = 4;
    end
  endtask
  function automatic logic [12:0] expect_out();
    bit v;
    logic [7:0] l;
    v = ph == 2;
    l = ph == 1 ? 8'(1 << who) : (ph == 2 || ph == 3) ? 8'hFF : ph == 5 ? tl[pick] : 8'h00;
    return o(v, v ? 2'(who) : 2'd0, rej, ph == 1 || ph == 2 || ph == 3, l);
  endfunction
  function automatic logic [12:0] actual();
    return {vote_valid, vote_cand, reject, busy, led};
  endfunction
  task automatic check(string name, logic [12:0] act, logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic check_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask
  task automatic cyc(logic rn, logic m, logic [3:0] b);
    reset = rn;
    mode = m;
    {button4, button3, button2, button1} = b;
    @(posedge clock);
    model_step(rn, m, b);
    @(negedge clock);
    check($sformatf("model t=%0t", $time), actual(), expect_out());
  endtask
  initial begin
    int nv, first_v, nb;
    logic [1:0] vc;
    logic rn, m;
    logic [3:0] b;
    tl = '{8'd3, 8'd5, 8'd7, 8'd9};
    tbl[0]  = '{1'b0, 1'b0, 4'b0000, o(0, 0, 0, 0, 8'h00)};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000, o(0, 0, 0, 0, 8'h00)};
    tbl[2]  = '{1'b1, 1'b0, 4'b0110, o(0, 0, 1, 0, 8'h00)};
    tbl[3]  = '{1'b1, 1'b0, 4'b0110, o(0, 0, 0, 0, 8'h00)};
    tbl[4]  = '{1'b1, 1'b0, 4'b0000, o(0, 0, 0, 0, 8'h00)};
    for (int i = 5; i < 10; i++) tbl[i] = '{1'b1, 1'b0, 4'b1000, o(0, 0, 0, 1, 8'h08)};
    tbl[10] = '{1'b1, 1'b0, 4'b0000, o(0, 0, 0, 0, 8'h00)};
    tbl[11] = '{1'b1, 1'b1, 4'b0000, o(0, 0, 0, 0, 8'd3)};
    tbl[12] = '{1'b1, 1'b1, 4'b0100, o(0, 0, 0, 0, 8'd7)};
    tbl[13] = '{1'b1, 1'b1, 4'b0000, o(0, 0, 0, 0, 8'd7)};
    tbl[14] = '{1'b1, 1'b0, 4'b0000, o(0, 0, 0, 0, 8'h00)};
    tbl[15] = '{1'b1, 1'b0, 4'b0000, o(0, 0, 0, 0, 8'h00)};
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rn, tbl[i].m, tbl[i].b);
      check($sformatf("vec %0d", i), actual(), tbl[i].exp);
    end
    nv = 0; first_v = -1; vc = 2'd3;
    for (int i = 1; i <= 40; i++) begin
      cyc(1, 0, 4'b0001);
      if (vote_valid) begin nv++; if (first_v < 0) begin first_v = i; vc = vote_cand; end end
    end
    check_int("hold votes", nv, 1);
    check_int("hold latency", first_v, H);
    check_int("hold cand", int'(vc), 0);
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0000);
    for (int i = 1; i <= 10; i++) cyc(1, 0, 4'b0010);
    check_int("pre-reset vote", int'(vote_valid), 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 4'b0000);
    cyc(0, 0, 4'b0000);
    check("reset in lockout", actual(), 13'd0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin cyc(1, 0, 4'b0000); if (vote_valid || busy) nv++; end
    check_int("post-reset quiet", nv, 0);
    nv = 0; first_v = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 0, 4'b0100);
      if (vote_valid) begin nv++; if (first_v < 0) begin first_v = i; vc = vote_cand; end end
    end
    check_int("re-press latency", first_v, H);
    check_int("re-press cand", int'(vc), 2);
    for (int i = 0; i < 20; i++) cyc(1, 0, 4'b0000);
    nv = 0;
    for (int i = 1; i <= 10; i++) begin cyc(1, 0, 4'b1000); if (vote_valid) nv++; end
    nb = 0;
    for (int i = 0; i < 16; i++) begin cyc(1, 1, 4'b0000); if (busy) nb++; if (vote_valid) nv++; end
    check_int("mode commit votes", nv, 1);
    check_int("mode lockout len", nb, L);
    cyc(1, 1, 4'b0000);
    check("mode result entry", actual(), o(0, 0, 0, 0, 8'd3));
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0000);
    rn = 1; m = 0; b = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      rn = ($urandom % 400) != 0;
      if ($urandom % 14 == 0) begin
        case ($urandom % 6)
          0, 1: b = 4'b0000;
          2, 3: b = 4'(1 << ($urandom % 4));
          4: b = 4'($urandom);
          default: b = b;
        endcase
      end
      if ($urandom % 60 == 0) m = ~m;
      if ($urandom % 50 == 0) tl[$urandom % 4] = 8'($urandom);
      cyc(rn, m, b);
      total++;
      if (vote_valid && reject) begin
        bad++;
        $display("FAIL valid_reject_overlap act=1 exp=0");
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 10, consecutive sampled cycles a lone button is held before a vote commits; legal range 2..255.
REQ-002 Parameter LOCKOUT_CYCLES, default 16, cycles spent in LOCKOUT after a commit; legal range 1..255.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 mode  in  1  0 = vote mode, 1 = result mode.
REQ-007 button1..button4  in  1 each  candidate buttons, level, synchronous to clock.
REQ-008 tally1..tally4  in  8 each  current counts from the external tally datapath.
REQ-009 vote_valid  out  1  one-cycle commit strobe to the tally datapath.
REQ-010 vote_cand  out  2  candidate index 0..3 (button1..button4); meaningful only when vote_valid=1.
REQ-011 reject  out  1  one-cycle strobe; illegal multi-button press detected.
REQ-012 busy  out  1  high in PRESS, COMMIT and LOCKOUT.
REQ-013 led  out  8  status or result display.

Function
REQ-014 The FSM SHALL have six states, IDLE, PRESS, COMMIT, LOCKOUT, WAIT_REL and RESULT, with an 8-bit hold counter and an 8-bit lockout counter.
REQ-015 IDLE, mode=0: exactly one button high SHALL latch cand, set hold_cnt=1 and go to PRESS; two or more high SHALL pulse reject for 1 cycle and go to WAIT_REL; none high SHALL stay in IDLE.
REQ-016 PRESS: if only the latched button is high, hold_cnt SHALL increment; on the edge where hold_cnt reaches HOLD_CYCLES the FSM SHALL go to COMMIT.
REQ-017 PRESS: latched button released early SHALL go to IDLE with no reject and no vote.
REQ-018 PRESS: any other button also high SHALL pulse reject and go to WAIT_REL with no vote.
REQ-019 Latency: a lone button sampled high on HOLD_CYCLES consecutive edges SHALL give vote_valid=1 in the cycle immediately after the last of those edges.
REQ-020 COMMIT SHALL last exactly 1 cycle with vote_valid=1 and vote_cand=latched index, then go to LOCKOUT with lock_cnt=0.
REQ-021 LOCKOUT SHALL ignore all buttons; lock_cnt SHALL increment each cycle, and exit to WAIT_REL (mode=0) or RESULT (mode=1) after LOCKOUT_CYCLES cycles.
REQ-022 WAIT_REL SHALL go to IDLE only when all buttons are low, so a button held continuously yields at most one vote.
REQ-023 mode=1 seen in IDLE or WAIT_REL SHALL go to RESULT next cycle; mode=1 in PRESS SHALL abort with no vote and go to RESULT.
REQ-024 mode=1 in COMMIT or LOCKOUT SHALL NOT suppress the commit; RESULT SHALL be entered at lockout exit.
REQ-025 RESULT: vote_valid SHALL stay 0; the lowest-numbered high button SHALL select the tally shown on led and that selection SHALL be held when buttons release; the initial selection is tally1.
REQ-026 RESULT: mode=0 SHALL go to WAIT_REL.
REQ-027 led in vote mode: IDLE/WAIT_REL 8'h00, PRESS one-hot latched cand in led[3:0], COMMIT/LOCKOUT 8'hFF.
REQ-028 reject and vote_valid SHALL never be high in the same cycle.
REQ-029 Counters SHALL saturate, never wrap.

Reset
REQ-030 reset=0 on a rising edge SHALL force IDLE from any state and clear the counters, the latched cand and the result selection.
REQ-031 reset=0 SHALL force vote_valid=0, vote_cand=0, reject=0, busy=0 and led=8'h00 from the next cycle.
REQ-032 Reset during COMMIT or LOCKOUT SHALL abandon the session without emitting a further vote_valid.

Structure
REQ-033 Shared package vm_pkg SHALL hold the state enum, the 2-bit candidate type, and the HOLD_CYCLES/LOCKOUT_CYCLES defaults.
REQ-034 One sub-module, vm_btn_decode, SHALL be combinational: the four buttons in, and out a count-is-one flag, a count-greater-than-one flag and the lowest index.

Verification
REQ-035 10 ns clock, button1 held 20 cycles -> exactly one vote_valid with vote_cand=0, 10 cycles after the first sampled edge; no second vote until release.
REQ-036 button2 and button3 asserted together -> reject pulse of 1 cycle, no vote_valid, IDLE after both release.
REQ-037 button4 held 5 cycles then released -> no vote_valid, no reject, IDLE.
REQ-038 mode=1, tally3=8'd7, button3 pulsed -> led=8'd7 and held after release; mode=0 -> led=8'h00.
REQ-039 reset=0 asserted in LOCKOUT cycle 3 -> all outputs zero next cycle, IDLE; a new 10-cycle press then commits normally.
REQ-040 mode raised during COMMIT -> vote_valid still seen once, RESULT entered after 16 lockout cycles.
